// File: rtl/piso_bit_feeder_if.sv
// piso_bit_feeder_if
// Handshake and serial-line bundle of the parallel-in/serial-out feeder.
// The master side is the upstream word producer plus the serial consumer;
// the slave side is the feeder itself.
interface piso_bit_feeder_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] DATA_IN;
  logic             DATA_VALID;
  logic             DATA_READY;
  logic             SER_OUT;
  logic             SER_VALID;
  logic             WORD_DONE;

  modport master (
    output DATA_IN,
    output DATA_VALID,
    input  DATA_READY,
    input  SER_OUT,
    input  SER_VALID,
    input  WORD_DONE
  );

  modport slave (
    input  DATA_IN,
    input  DATA_VALID,
    output DATA_READY,
    output SER_OUT,
    output SER_VALID,
    output WORD_DONE
  );

endinterface

// File: rtl/piso_bit_feeder.sv
// piso_bit_feeder
// Takes WIDTH-bit words over a valid/ready handshake and plays them out one
// bit per clock on a registered serial line feeding the 1101 detector.
// Between words the line sits at IDLE_LEVEL with SER_VALID low.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit to
// every word (adds the PAR state; WORD_DONE then marks the parity cycle).
module piso_bit_feeder #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               CLK,
  input  logic               RST,
  piso_bit_feeder_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Counter value while the final data bit is on the line, and the one before it
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             data_ready;
  logic             accept;
  logic             last_bit;

  // The shift register holds the bits still to be sent; the bit on the line
  // lives in ser_out_q, so loading puts bit 0 out and keeps the remainder.
  logic             load_bit;
  logic [WIDTH-1:0] load_rest;
  logic             step_bit;
  logic [WIDTH-1:0] step_rest;

  assign load_bit  = MSB_FIRST ? bus.DATA_IN[WIDTH-1] : bus.DATA_IN[0];
  assign load_rest = MSB_FIRST ? {bus.DATA_IN[WIDTH-2:0], 1'b0}
                               : {1'b0, bus.DATA_IN[WIDTH-1:1]};
  assign step_bit  = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign step_rest = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_q[WIDTH-1:1]};

  assign last_bit  = (cnt_q == LAST_BIT);
  assign accept    = bus.DATA_VALID && data_ready;

  // Ready is high when idle, on the parity cycle, and on the last data bit
  // only when that bit can hand off directly to the next word.
  always_comb begin
    data_ready = 1'b0;
    case (state_q)
      ST_IDLE:  data_ready = 1'b1;
`ifdef PISO_PARITY_EN
      ST_SHIFT: data_ready = 1'b0;
      ST_PAR:   data_ready = 1'b1;
`else
      ST_SHIFT: data_ready = last_bit;
`endif
      default:  data_ready = 1'b0;
    endcase
  end

  // Next-state and next-output logic; an accepted word always restarts at
  // bit 0 regardless of which state granted ready.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    ser_out_d   = IDLE_LEVEL;
    ser_valid_d = 1'b0;
    word_done_d = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d    = parity_q;
`endif

    if (accept) begin
      state_d     = ST_SHIFT;
      shift_d     = load_rest;
      cnt_d       = '0;
      ser_out_d   = load_bit;
      ser_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
      parity_d    = ^bus.DATA_IN;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SHIFT: begin
          if (!last_bit) begin
            shift_d     = step_rest;
            cnt_d       = cnt_q + CNT_W'(1);
            ser_out_d   = step_bit;
            ser_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
            word_done_d = 1'b0;
`else
            word_done_d = (cnt_q == PRE_LAST);
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state_d     = ST_PAR;
            ser_out_d   = parity_q;
            ser_valid_d = 1'b1;
            word_done_d = 1'b1;
`else
            state_d     = ST_IDLE;
            cnt_d       = '0;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        ST_PAR: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
`endif
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers; reset drops any partial word at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
`ifdef PISO_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign bus.DATA_READY = data_ready;
  assign bus.SER_OUT    = ser_out_q;
  assign bus.SER_VALID  = ser_valid_q;
  assign bus.WORD_DONE  = word_done_q;

endmodule

// File: tb/tb_piso_bit_feeder.sv
// tb_piso_bit_feeder
// Directed bench for piso_bit_feeder with three instances: WIDTH=8 MSB-first,
// WIDTH=4 MSB-first and WIDTH=4 LSB-first. Expected timing follows the
// PISO_PARITY_EN setting of the build.
module tb_piso_bit_feeder;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L8 = 8 + PAR;
  localparam int L4 = 4 + PAR;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  piso_bit_feeder_if #(.WIDTH(8)) if8 ();
  piso_bit_feeder_if #(.WIDTH(4)) if4 ();
  piso_bit_feeder_if #(.WIDTH(4)) if4l ();

  piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut8 (
    .CLK(clk), .RST(rst_n), .bus(if8.slave));
  piso_bit_feeder #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut4 (
    .CLK(clk), .RST(rst_n), .bus(if4.slave));
  piso_bit_feeder #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut4l (
    .CLK(clk), .RST(rst_n), .bus(if4l.slave));

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference 1101 detector on the WIDTH=4 MSB-first line: history of valid bits
  logic [2:0] det_hist;
  logic       det_out;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) det_hist <= '0;
    else if (if4.SER_VALID) det_hist <= {det_hist[1:0], if4.SER_OUT};
  end
  assign det_out = if4.SER_VALID && ({det_hist, if4.SER_OUT} == 4'b1101);

  task automatic test_reset();
    rst_n = 1'b0;
    if8.DATA_IN = 8'hFF;
    if8.DATA_VALID = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (if8.SER_OUT !== 1'b0) $display("[TB] FAIL reset_ser_out: got %b want 0", if8.SER_OUT); else passes++;
    checks++; if (if8.SER_VALID !== 1'b0) $display("[TB] FAIL reset_ser_valid: got %b want 0", if8.SER_VALID); else passes++;
    checks++; if (if8.WORD_DONE !== 1'b0) $display("[TB] FAIL reset_word_done: got %b want 0", if8.WORD_DONE); else passes++;
    checks++; if (if8.DATA_READY !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", if8.DATA_READY); else passes++;
    if8.DATA_VALID = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (if8.SER_VALID !== 1'b0) $display("[TB] FAIL post_reset_ser_valid: got %b want 0", if8.SER_VALID); else passes++;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (if4.SER_OUT !== 1'b0) $display("[TB] FAIL idle_ser_out c=%0d: got %b want 0", c, if4.SER_OUT); else passes++;
      checks++; if (if4.SER_VALID !== 1'b0) $display("[TB] FAIL idle_ser_valid c=%0d: got %b want 0", c, if4.SER_VALID); else passes++;
      checks++; if (if4.DATA_READY !== 1'b1) $display("[TB] FAIL idle_ready c=%0d: got %b want 1", c, if4.DATA_READY); else passes++;
      if4.DATA_IN = 4'(c * 5 + 3);
    end
  endtask

  task automatic test_basic();
    logic [3:0] w;
    logic       exp_bit;
    w = 4'b1101;
    @(negedge clk);
    if4.DATA_IN = w;
    if4.DATA_VALID = 1'b1;
    for (int i = 1; i <= L4; i++) begin
      @(negedge clk);
      exp_bit = (i <= 4) ? w[4 - i] : ^w;
      checks++; if (if4.SER_OUT !== exp_bit) $display("[TB] FAIL basic_bit%0d: got %b want %b", i, if4.SER_OUT, exp_bit); else passes++;
      checks++; if (if4.SER_VALID !== 1'b1) $display("[TB] FAIL basic_valid%0d: got %b want 1", i, if4.SER_VALID); else passes++;
      checks++; if (if4.WORD_DONE !== (i == L4)) $display("[TB] FAIL basic_done%0d: got %b want %b", i, if4.WORD_DONE, (i == L4)); else passes++;
      checks++; if (if4.DATA_READY !== (i == L4)) $display("[TB] FAIL basic_ready%0d: got %b want %b", i, if4.DATA_READY, (i == L4)); else passes++;
      if (i == 3) begin
        checks++; if (det_out !== 1'b0) $display("[TB] FAIL basic_det_early: got %b want 0", det_out); else passes++;
      end
      if (i == 4) begin
        checks++; if (det_out !== 1'b1) $display("[TB] FAIL basic_det_hit: got %b want 1", det_out); else passes++;
      end
      if4.DATA_VALID = 1'b0;
    end
    @(negedge clk);
    checks++; if (if4.SER_OUT !== 1'b0) $display("[TB] FAIL basic_idle_out: got %b want 0", if4.SER_OUT); else passes++;
    checks++; if (if4.SER_VALID !== 1'b0) $display("[TB] FAIL basic_idle_valid: got %b want 0", if4.SER_VALID); else passes++;
  endtask

  task automatic test_lsb_first();
    logic [3:0] w;
    logic [4:0] exp_seq;
    w = 4'b1011;
    // Sent order: 1,1,0,1 then parity 1 when enabled
    exp_seq = 5'b11011;
    @(negedge clk);
    if4l.DATA_IN = w;
    if4l.DATA_VALID = 1'b1;
    for (int i = 1; i <= L4; i++) begin
      @(negedge clk);
      checks++; if (if4l.SER_OUT !== exp_seq[5 - i]) $display("[TB] FAIL lsb_bit%0d: got %b want %b", i, if4l.SER_OUT, exp_seq[5 - i]); else passes++;
      checks++; if (if4l.SER_VALID !== 1'b1) $display("[TB] FAIL lsb_valid%0d: got %b want 1", i, if4l.SER_VALID); else passes++;
      checks++; if (if4l.WORD_DONE !== (i == L4)) $display("[TB] FAIL lsb_done%0d: got %b want %b", i, if4l.WORD_DONE, (i == L4)); else passes++;
      if4l.DATA_VALID = 1'b0;
    end
    @(negedge clk);
    checks++; if (if4l.SER_VALID !== 1'b0) $display("[TB] FAIL lsb_idle_valid: got %b want 0", if4l.SER_VALID); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] word;
    logic       exp_bit;
    int         pos;
    @(negedge clk);
    checks++; if (if8.DATA_READY !== 1'b1) $display("[TB] FAIL b2b_ready_k: got %b want 1", if8.DATA_READY); else passes++;
    if8.DATA_IN = 8'hA5;
    if8.DATA_VALID = 1'b1;
    for (int c = 1; c <= 2 * L8; c++) begin
      @(negedge clk);
      word = (c <= L8) ? 8'hA5 : 8'h3C;
      pos = (c - 1) % L8;
      exp_bit = (pos < 8) ? word[7 - pos] : ^word;
      checks++; if (if8.SER_OUT !== exp_bit) $display("[TB] FAIL b2b_bit%0d: got %b want %b", c, if8.SER_OUT, exp_bit); else passes++;
      checks++; if (if8.SER_VALID !== 1'b1) $display("[TB] FAIL b2b_valid%0d: got %b want 1", c, if8.SER_VALID); else passes++;
      checks++; if (if8.DATA_READY !== (pos == L8 - 1)) $display("[TB] FAIL b2b_ready%0d: got %b want %b", c, if8.DATA_READY, (pos == L8 - 1)); else passes++;
      checks++; if (if8.WORD_DONE !== (pos == L8 - 1)) $display("[TB] FAIL b2b_done%0d: got %b want %b", c, if8.WORD_DONE, (pos == L8 - 1)); else passes++;
      if (c == 1) if8.DATA_IN = 8'h3C;
      if (c == L8 + 1) if8.DATA_VALID = 1'b0;
    end
    @(negedge clk);
    checks++; if (if8.SER_VALID !== 1'b0) $display("[TB] FAIL b2b_end_valid: got %b want 0", if8.SER_VALID); else passes++;
    checks++; if (if8.SER_OUT !== 1'b0) $display("[TB] FAIL b2b_end_out: got %b want 0", if8.SER_OUT); else passes++;
  endtask

  task automatic test_parity();
    logic [7:0] words [2];
    logic       par_exp [2];
    logic       exp_bit;
    words[0] = 8'hA5; par_exp[0] = 1'b0;
    words[1] = 8'h07; par_exp[1] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      if8.DATA_IN = words[n];
      if8.DATA_VALID = 1'b1;
      for (int c = 1; c <= L8; c++) begin
        @(negedge clk);
        exp_bit = (c <= 8) ? words[n][8 - c] : par_exp[n];
        checks++; if (if8.SER_OUT !== exp_bit) $display("[TB] FAIL par_w%0d_bit%0d: got %b want %b", n, c, if8.SER_OUT, exp_bit); else passes++;
        checks++; if (if8.SER_VALID !== 1'b1) $display("[TB] FAIL par_w%0d_valid%0d: got %b want 1", n, c, if8.SER_VALID); else passes++;
        checks++; if (if8.DATA_READY !== (c == L8)) $display("[TB] FAIL par_w%0d_ready%0d: got %b want %b", n, c, if8.DATA_READY, (c == L8)); else passes++;
        checks++; if (if8.WORD_DONE !== (c == L8)) $display("[TB] FAIL par_w%0d_done%0d: got %b want %b", n, c, if8.WORD_DONE, (c == L8)); else passes++;
        if8.DATA_VALID = 1'b0;
      end
      @(negedge clk);
      checks++; if (if8.SER_VALID !== 1'b0) $display("[TB] FAIL par_w%0d_idle: got %b want 0", n, if8.SER_VALID); else passes++;
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    @(negedge clk);
    if8.DATA_IN = 8'hFF;
    if8.DATA_VALID = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (if8.SER_OUT !== 1'b1) $display("[TB] FAIL mid_bit%0d: got %b want 1", i, if8.SER_OUT); else passes++;
      if8.DATA_VALID = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if8.SER_OUT !== 1'b0) $display("[TB] FAIL mid_rst_out: got %b want 0", if8.SER_OUT); else passes++;
    checks++; if (if8.SER_VALID !== 1'b0) $display("[TB] FAIL mid_rst_valid: got %b want 0", if8.SER_VALID); else passes++;
    checks++; if (if8.WORD_DONE !== 1'b0) $display("[TB] FAIL mid_rst_done: got %b want 0", if8.WORD_DONE); else passes++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (if8.WORD_DONE !== 1'b0) $display("[TB] FAIL mid_hold_done%0d: got %b want 0", i, if8.WORD_DONE); else passes++;
      checks++; if (if8.SER_OUT !== 1'b0) $display("[TB] FAIL mid_hold_out%0d: got %b want 0", i, if8.SER_OUT); else passes++;
    end
    w = 8'h0F;
    rst_n = 1'b1;
    if8.DATA_IN = w;
    if8.DATA_VALID = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (if8.SER_OUT !== w[8 - c]) $display("[TB] FAIL mid_new_bit%0d: got %b want %b", c, if8.SER_OUT, w[8 - c]); else passes++;
      checks++; if (if8.SER_VALID !== 1'b1) $display("[TB] FAIL mid_new_valid%0d: got %b want 1", c, if8.SER_VALID); else passes++;
      checks++; if (if8.WORD_DONE !== (c == 8 && PAR == 0)) $display("[TB] FAIL mid_new_done%0d: got %b want %b", c, if8.WORD_DONE, (c == 8 && PAR == 0)); else passes++;
      if8.DATA_VALID = 1'b0;
    end
    repeat (PAR + 1) @(negedge clk);
    checks++; if (if8.SER_VALID !== 1'b0) $display("[TB] FAIL mid_new_idle: got %b want 0", if8.SER_VALID); else passes++;
  endtask

  // Test sequence
  initial begin
    checks = 0;
    passes = 0;
    if4.DATA_IN = '0;
    if4.DATA_VALID = 1'b0;
    if4l.DATA_IN = '0;
    if4l.DATA_VALID = 1'b0;
    if8.DATA_IN = '0;
    if8.DATA_VALID = 1'b0;
    $display("[TB] start, parity=%0d", PAR);
    test_reset();
    test_idle();
    test_basic();
    test_lsb_first();
    test_back_to_back();
    test_parity();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
